// File: rtl/mby_tag_ring_uc_node.sv
// Unicast tag ring stop: ejects tags addressed to NODE_ID and injects local tags
// from NUM_CH buffered channels into free slots under round-robin arbitration.
module mby_tag_ring_uc_node #(
  parameter int TAG_W      = 64,
  parameter int NODE_ID_W  = 4,
  parameter int NODE_ID    = 0,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ring_in_valid,
  input  logic [NODE_ID_W-1:0]        ring_in_dest,
  input  logic [TAG_W-1:0]            ring_in_data,
  output logic                        ring_out_valid,
  output logic [NODE_ID_W-1:0]        ring_out_dest,
  output logic [TAG_W-1:0]            ring_out_data,
  input  logic [NUM_CH-1:0]           inj_valid,
  output logic [NUM_CH-1:0]           inj_ready,
  input  logic [NUM_CH*NODE_ID_W-1:0] inj_dest,
  input  logic [NUM_CH*TAG_W-1:0]     inj_data,
  input  logic                        ej_ready,
  output logic                        ej_valid,
  output logic [TAG_W-1:0]            ej_data,
  output logic [CNT_W-1:0]            inj_cnt,
  output logic [CNT_W-1:0]            ej_cnt,
  output logic [CNT_W-1:0]            defl_cnt
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = ADDR_W + 1;

  localparam logic [NODE_ID_W-1:0] MY_ID     = NODE_ID_W'(NODE_ID);
  localparam logic [OCC_W-1:0]     DEPTH_OCC = OCC_W'(FIFO_DEPTH);
  localparam logic [CH_W-1:0]      LAST_CH   = CH_W'(NUM_CH - 1);

  typedef struct packed {
    logic [NODE_ID_W-1:0] dest;
    logic [TAG_W-1:0]     data;
  } tag_t;

  // Injection FIFO state
  tag_t              mem_q    [NUM_CH][FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q [NUM_CH];
  logic [ADDR_W-1:0] rd_ptr_q [NUM_CH];
  logic [OCC_W-1:0]  occ_q    [NUM_CH];
  logic [OCC_W-1:0]  occ_d    [NUM_CH];
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] fifo_push;
  logic [NUM_CH-1:0] fifo_pop;
  logic              rdy_en_q;

  // Arbitration
  logic [CH_W-1:0]   rr_ptr_q;
  logic [CH_W-1:0]   rr_ptr_d;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_ch;
  tag_t              grant_tag;
  int                arb_idx;

  // Slot decode
  logic              to_me;
  logic              ejecting;
  logic              deflecting;
  logic              slot_free;

  // Output registers
  logic              ring_out_valid_q;
  logic              ring_out_valid_d;
  tag_t              ring_out_q;
  tag_t              ring_out_d;
  logic              ej_valid_q;
  logic [TAG_W-1:0]  ej_data_q;
  logic [CNT_W-1:0]  inj_cnt_q;
  logic [CNT_W-1:0]  ej_cnt_q;
  logic [CNT_W-1:0]  defl_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  assign to_me      = ring_in_valid && (ring_in_dest == MY_ID);
  assign ejecting   = to_me && ej_ready;
  assign deflecting = to_me && !ej_ready;
  assign slot_free  = !ring_in_valid || ejecting;

  // inj_ready is held low until the first clock after reset release.
  assign inj_ready  = rdy_en_q ? ~full : '0;

  always_comb begin
    full      = '0;
    nonempty  = '0;
    fifo_push = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      full[c]      = (occ_q[c] == DEPTH_OCC);
      nonempty[c]  = (occ_q[c] != '0);
      fifo_push[c] = inj_valid[c] && rdy_en_q && !full[c];
    end
  end

  // Only registered occupancy feeds the arbiter, so a tag pushed this cycle
  // cannot be granted until the next one.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    arb_idx   = 0;
    if (slot_free) begin
      for (int k = 0; k < NUM_CH; k++) begin
        arb_idx = int'(rr_ptr_q) + k;
        if (arb_idx >= NUM_CH) arb_idx = arb_idx - NUM_CH;
        if (!grant_vld && nonempty[CH_W'(arb_idx)]) begin
          grant_vld = 1'b1;
          grant_ch  = CH_W'(arb_idx);
        end
      end
    end
  end

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves a variable unassigned would infer a latch.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    fifo_pop  = '0;
    grant_tag = '0;
    if (grant_vld) rr_ptr_d = (grant_ch == LAST_CH) ? '0 : grant_ch + CH_W'(1);
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_vld && (grant_ch == CH_W'(c))) begin
        fifo_pop[c] = 1'b1;
        grant_tag   = mem_q[c][rd_ptr_q[c]];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      occ_d[c] = occ_q[c];
      case ({fifo_push[c], fifo_pop[c]})
        2'b10:   occ_d[c] = occ_q[c] + OCC_W'(1);
        2'b01:   occ_d[c] = occ_q[c] - OCC_W'(1);
        default: occ_d[c] = occ_q[c];
      endcase
    end
  end

  // A non-ejected valid slot always wins; injection only fills a free slot.
  always_comb begin
    ring_out_valid_d = 1'b0;
    ring_out_d       = '0;
    if (ring_in_valid && !ejecting) begin
      ring_out_valid_d = 1'b1;
      ring_out_d.dest  = ring_in_dest;
      ring_out_d.data  = ring_in_data;
    end else if (grant_vld) begin
      ring_out_valid_d = 1'b1;
      ring_out_d       = grant_tag;
    end
  end

  // NOTE: the FIFO storage has no reset; pointers and occupancy alone decide
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (fifo_push[c]) begin
        mem_q[c][wr_ptr_q[c]] <= {inj_dest[c*NODE_ID_W +: NODE_ID_W],
                                  inj_data[c*TAG_W +: TAG_W]};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en_q         <= 1'b0;
      rr_ptr_q         <= '0;
      ring_out_valid_q <= 1'b0;
      ring_out_q       <= '0;
      ej_valid_q       <= 1'b0;
      ej_data_q        <= '0;
      inj_cnt_q        <= '0;
      ej_cnt_q         <= '0;
      defl_cnt_q       <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        occ_q[c]    <= '0;
      end
    end else begin
      rdy_en_q         <= 1'b1;
      rr_ptr_q         <= rr_ptr_d;
      ring_out_valid_q <= ring_out_valid_d;
      ring_out_q       <= ring_out_d;
      ej_valid_q       <= ejecting;
      ej_data_q        <= ejecting ? ring_in_data : '0;
      inj_cnt_q        <= sat_inc(inj_cnt_q, grant_vld);
      ej_cnt_q         <= sat_inc(ej_cnt_q, ejecting);
      defl_cnt_q       <= sat_inc(defl_cnt_q, deflecting);
      for (int c = 0; c < NUM_CH; c++) begin
        occ_q[c] <= occ_d[c];
        if (fifo_push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + ADDR_W'(1);
        if (fifo_pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + ADDR_W'(1);
      end
    end
  end

  assign ring_out_valid = ring_out_valid_q;
  assign ring_out_dest  = ring_out_q.dest;
  assign ring_out_data  = ring_out_q.data;
  assign ej_valid       = ej_valid_q;
  assign ej_data        = ej_data_q;
  assign inj_cnt        = inj_cnt_q;
  assign ej_cnt         = ej_cnt_q;
  assign defl_cnt       = defl_cnt_q;

endmodule

// File: tb/tb_mby_tag_ring_uc_node.sv
// Bench for the unicast tag ring stop: table vectors, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_mby_tag_ring_uc_node;

  localparam int TAG_W      = 64;
  localparam int NODE_ID_W  = 4;
  localparam int NODE_ID    = 0;
  localparam int NUM_CH     = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 16;
  localparam int SAT_W      = 2;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        ring_in_valid;
  logic [NODE_ID_W-1:0]        ring_in_dest;
  logic [TAG_W-1:0]            ring_in_data;
  logic                        ring_out_valid;
  logic [NODE_ID_W-1:0]        ring_out_dest;
  logic [TAG_W-1:0]            ring_out_data;
  logic [NUM_CH-1:0]           inj_valid;
  logic [NUM_CH-1:0]           inj_ready;
  logic [NUM_CH*NODE_ID_W-1:0] inj_dest;
  logic [NUM_CH*TAG_W-1:0]     inj_data;
  logic                        ej_ready;
  logic                        ej_valid;
  logic [TAG_W-1:0]            ej_data;
  logic [CNT_W-1:0]            inj_cnt;
  logic [CNT_W-1:0]            ej_cnt;
  logic [CNT_W-1:0]            defl_cnt;

  // Second instance with narrow counters, fed the same stimulus.
  logic                        s_ring_out_valid;
  logic [NODE_ID_W-1:0]        s_ring_out_dest;
  logic [TAG_W-1:0]            s_ring_out_data;
  logic [NUM_CH-1:0]           s_inj_ready;
  logic                        s_ej_valid;
  logic [TAG_W-1:0]            s_ej_data;
  logic [SAT_W-1:0]            s_inj_cnt;
  logic [SAT_W-1:0]            s_ej_cnt;
  logic [SAT_W-1:0]            s_defl_cnt;

  always #5 clk = ~clk;

  mby_tag_ring_uc_node #(
    .TAG_W(TAG_W), .NODE_ID_W(NODE_ID_W), .NODE_ID(NODE_ID),
    .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst(rst),
    .ring_in_valid(ring_in_valid), .ring_in_dest(ring_in_dest), .ring_in_data(ring_in_data),
    .ring_out_valid(ring_out_valid), .ring_out_dest(ring_out_dest), .ring_out_data(ring_out_data),
    .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_dest(inj_dest), .inj_data(inj_data),
    .ej_ready(ej_ready), .ej_valid(ej_valid), .ej_data(ej_data),
    .inj_cnt(inj_cnt), .ej_cnt(ej_cnt), .defl_cnt(defl_cnt)
  );

  mby_tag_ring_uc_node #(
    .TAG_W(TAG_W), .NODE_ID_W(NODE_ID_W), .NODE_ID(NODE_ID),
    .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(SAT_W)
  ) u_sat (
    .clk(clk), .rst(rst),
    .ring_in_valid(ring_in_valid), .ring_in_dest(ring_in_dest), .ring_in_data(ring_in_data),
    .ring_out_valid(s_ring_out_valid), .ring_out_dest(s_ring_out_dest), .ring_out_data(s_ring_out_data),
    .inj_valid(inj_valid), .inj_ready(s_inj_ready), .inj_dest(inj_dest), .inj_data(inj_data),
    .ej_ready(ej_ready), .ej_valid(s_ej_valid), .ej_data(s_ej_data),
    .inj_cnt(s_inj_cnt), .ej_cnt(s_ej_cnt), .defl_cnt(s_defl_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [NODE_ID_W-1:0] dest;
    logic [TAG_W-1:0]     data;
  } tag_t;

  tag_t              fq [NUM_CH][$];
  int                m_rr;
  bit                m_ready_en;
  int                m_inj, m_ej, m_defl;
  bit                e_rv;
  logic [NODE_ID_W-1:0] e_rd;
  logic [TAG_W-1:0]  e_rdata;
  bit                e_ejv;
  logic [TAG_W-1:0]  e_ejd;

  function automatic int sat(input int v);
    return (v > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) fq[c].delete();
    m_rr = 0; m_ready_en = 0;
    m_inj = 0; m_ej = 0; m_defl = 0;
    e_rv = 0; e_rd = '0; e_rdata = '0; e_ejv = 0; e_ejd = '0;
  endtask

  // Computes the state visible after the coming clock edge from current inputs.
  task automatic model_step();
    bit   rdy [NUM_CH];
    bit   mine, ej, free_slot;
    int   g;
    tag_t t;
    for (int c = 0; c < NUM_CH; c++) rdy[c] = m_ready_en && (fq[c].size() < FIFO_DEPTH);
    mine      = ring_in_valid && (ring_in_dest == NODE_ID_W'(NODE_ID));
    ej        = mine && ej_ready;
    free_slot = !ring_in_valid || ej;
    g = -1;
    if (free_slot) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (g < 0 && fq[(m_rr + k) % NUM_CH].size() > 0) g = (m_rr + k) % NUM_CH;
      end
    end
    e_ejv = ej;
    e_ejd = ej ? ring_in_data : '0;
    if (ring_in_valid && !ej) begin
      e_rv = 1; e_rd = ring_in_dest; e_rdata = ring_in_data;
    end else if (g >= 0) begin
      t = fq[g].pop_front();
      e_rv = 1; e_rd = t.dest; e_rdata = t.data;
      m_rr = (g + 1) % NUM_CH;
      m_inj = sat(m_inj + 1);
    end else begin
      e_rv = 0; e_rd = '0; e_rdata = '0;
    end
    if (ej) m_ej = sat(m_ej + 1);
    if (mine && !ej_ready) m_defl = sat(m_defl + 1);
    for (int c = 0; c < NUM_CH; c++) begin
      if (inj_valid[c] && rdy[c]) begin
        t.dest = inj_dest[c*NODE_ID_W +: NODE_ID_W];
        t.data = inj_data[c*TAG_W +: TAG_W];
        fq[c].push_back(t);
      end
    end
    m_ready_en = 1;
  endtask

  function automatic logic [NUM_CH-1:0] exp_ready();
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = m_ready_en && (fq[c].size() < FIFO_DEPTH);
    return r;
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".ring_out_valid"}, 64'(ring_out_valid), 64'(e_rv));
    check({tag, ".ring_out_dest"},  64'(ring_out_dest),  64'(e_rd));
    check({tag, ".ring_out_data"},  ring_out_data,       e_rdata);
    check({tag, ".ej_valid"},       64'(ej_valid),       64'(e_ejv));
    if (e_ejv) check({tag, ".ej_data"}, ej_data, e_ejd);
    check({tag, ".inj_ready"},      64'(inj_ready),      64'(exp_ready()));
    check({tag, ".inj_cnt"},        64'(inj_cnt),        64'(m_inj));
    check({tag, ".ej_cnt"},         64'(ej_cnt),         64'(m_ej));
    check({tag, ".defl_cnt"},       64'(defl_cnt),       64'(m_defl));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ring(input logic v, input logic [NODE_ID_W-1:0] d, input logic [TAG_W-1:0] data);
    ring_in_valid = v; ring_in_dest = d; ring_in_data = data;
  endtask

  task automatic push(input int c, input logic [NODE_ID_W-1:0] d, input logic [TAG_W-1:0] data);
    inj_valid[c] = 1'b1;
    inj_dest[c*NODE_ID_W +: NODE_ID_W] = d;
    inj_data[c*TAG_W +: TAG_W] = data;
  endtask

  task automatic clear_inputs();
    set_ring(1'b0, '0, '0);
    inj_valid = '0; inj_dest = '0; inj_data = '0;
    ej_ready = 1'b1;
  endtask

  // Ends one idle clock after release, so inj_ready is already up.
  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step();
  endtask

  typedef struct {
    logic                 v;
    logic [NODE_ID_W-1:0] d;
    logic [TAG_W-1:0]     data;
    logic                 ejr;
    logic                 e_v;
    logic [NODE_ID_W-1:0] e_d;
    logic [TAG_W-1:0]     e_data;
    logic                 e_ejv;
    logic [TAG_W-1:0]     e_ejd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b0, 4'd0,  64'h0,                   1'b1, 1'b0, 4'd0,  64'h0,                   1'b0, 64'h0};
    vecs[1] = '{1'b1, 4'd3,  64'hA5,                  1'b1, 1'b1, 4'd3,  64'hA5,                  1'b0, 64'h0};
    vecs[2] = '{1'b1, 4'd0,  64'h11,                  1'b1, 1'b0, 4'd0,  64'h0,                   1'b1, 64'h11};
    vecs[3] = '{1'b1, 4'd0,  64'h33,                  1'b0, 1'b1, 4'd0,  64'h33,                  1'b0, 64'h0};
    vecs[4] = '{1'b1, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0};
    vecs[5] = '{1'b1, 4'd0,  64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b0, 4'd0,  64'h0,                   1'b1, 64'hDEAD_BEEF_CAFE_F00D};

    // Reset with a busy ring and pending injections: everything stays at zero.
    rst = 1'b0;
    clear_inputs();
    set_ring(1'b1, 4'd0, 64'h5);
    inj_valid = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst.ring_out_valid", 64'(ring_out_valid), 64'h0);
    check("rst.ring_out_dest",  64'(ring_out_dest),  64'h0);
    check("rst.ring_out_data",  ring_out_data,       64'h0);
    check("rst.ej_valid",       64'(ej_valid),       64'h0);
    check("rst.ej_data",        ej_data,             64'h0);
    check("rst.inj_ready",      64'(inj_ready),      64'h0);
    check("rst.inj_cnt",        64'(inj_cnt),        64'h0);
    check("rst.ej_cnt",         64'(ej_cnt),         64'h0);
    check("rst.defl_cnt",       64'(defl_cnt),       64'h0);
    clear_inputs();
    rst = 1'b1;
    step();
    check("rel.inj_ready",      64'(inj_ready),      64'hF);
    check("rel.ring_out_valid", 64'(ring_out_valid), 64'h0);
    check("rel.inj_cnt",        64'(inj_cnt),        64'h0);
    check("rel.ej_cnt",         64'(ej_cnt),         64'h0);

    // Table vectors with empty FIFOs: idle, pass, eject, deflect.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_ring(vecs[i].v, vecs[i].d, vecs[i].data);
      ej_ready = vecs[i].ejr;
      step();
      check($sformatf("vec%0d.ring_out_valid", i), 64'(ring_out_valid), 64'(vecs[i].e_v));
      check($sformatf("vec%0d.ring_out_dest", i),  64'(ring_out_dest),  64'(vecs[i].e_d));
      check($sformatf("vec%0d.ring_out_data", i),  ring_out_data,       vecs[i].e_data);
      check($sformatf("vec%0d.ej_valid", i),       64'(ej_valid),       64'(vecs[i].e_ejv));
      if (vecs[i].e_ejv) check($sformatf("vec%0d.ej_data", i), ej_data, vecs[i].e_ejd);
    end
    check_model("vec_end");

    // Pass-through blocks injection while ch0 holds a tag.
    do_reset();
    set_ring(1'b1, 4'd3, 64'h5);
    push(0, 4'd7, 64'h77);
    step();
    inj_valid = '0;
    set_ring(1'b1, 4'd3, 64'hA5);
    step();
    check("pt.ring_out_valid", 64'(ring_out_valid), 64'h1);
    check("pt.ring_out_dest",  64'(ring_out_dest),  64'h3);
    check("pt.ring_out_data",  ring_out_data,       64'hA5);
    check("pt.inj_cnt",        64'(inj_cnt),        64'h0);
    set_ring(1'b0, '0, '0);
    step();
    check("pt.inj_dest",       64'(ring_out_dest),  64'h7);
    check("pt.inj_data",       ring_out_data,       64'h77);
    check("pt.inj_cnt_after",  64'(inj_cnt),        64'h1);

    // Eject and inject into the same slot.
    do_reset();
    set_ring(1'b1, 4'd3, 64'h1);
    push(2, 4'd5, 64'h22);
    step();
    inj_valid = '0;
    set_ring(1'b1, 4'd0, 64'h11);
    ej_ready = 1'b1;
    step();
    check("ejinj.ej_valid",       64'(ej_valid),       64'h1);
    check("ejinj.ej_data",        ej_data,             64'h11);
    check("ejinj.ring_out_valid", 64'(ring_out_valid), 64'h1);
    check("ejinj.ring_out_dest",  64'(ring_out_dest),  64'h5);
    check("ejinj.ring_out_data",  ring_out_data,       64'h22);
    check("ejinj.ej_cnt",         64'(ej_cnt),         64'h1);
    check("ejinj.inj_cnt",        64'(inj_cnt),        64'h1);

    // Deflect when the sink is not ready.
    do_reset();
    set_ring(1'b1, 4'd0, 64'h44);
    ej_ready = 1'b0;
    step();
    check("defl.ring_out_valid", 64'(ring_out_valid), 64'h1);
    check("defl.ring_out_dest",  64'(ring_out_dest),  64'h0);
    check("defl.ring_out_data",  ring_out_data,       64'h44);
    check("defl.ej_valid",       64'(ej_valid),       64'h0);
    check("defl.defl_cnt",       64'(defl_cnt),       64'h1);

    // Round-robin: 3 tags per channel, then an empty ring drains 0,1,2,3,...
    do_reset();
    set_ring(1'b1, 4'd3, 64'hBB);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < NUM_CH; c++) push(c, NODE_ID_W'(c + 1), 64'(c * 256 + k));
      step();
    end
    inj_valid = '0;
    set_ring(1'b0, '0, '0);
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("rr%0d.valid", i), 64'(ring_out_valid),      64'h1);
      check($sformatf("rr%0d.ch", i),    64'(ring_out_data[15:8]), 64'(i % NUM_CH));
      check($sformatf("rr%0d.seq", i),   64'(ring_out_data[7:0]),  64'(i / NUM_CH));
    end
    step();
    check("idle.ring_out_valid", 64'(ring_out_valid), 64'h0);
    check("idle.ring_out_dest",  64'(ring_out_dest),  64'h0);
    check("idle.ring_out_data",  ring_out_data,       64'h0);

    // Full FIFO on a fully occupied ring; 9th request must be refused.
    do_reset();
    set_ring(1'b1, 4'd3, 64'hCC);
    for (int k = 1; k <= FIFO_DEPTH; k++) begin
      push(1, 4'd2, 64'(k));
      step();
      if (k == FIFO_DEPTH - 1) check("full.ready_before_last", 64'(inj_ready[1]), 64'h1);
    end
    check("full.ready_after_8", 64'(inj_ready[1]), 64'h0);
    push(1, 4'd2, 64'h99);
    step();
    check("full.ready_after_9", 64'(inj_ready[1]), 64'h0);
    inj_valid = '0;
    set_ring(1'b0, '0, '0);
    for (int k = 1; k <= FIFO_DEPTH; k++) begin
      step();
      check($sformatf("full.drain%0d", k), ring_out_data, 64'(k));
    end
    step();
    check("full.no_ninth", 64'(ring_out_valid), 64'h0);

    // Counter saturation on the narrow instance.
    do_reset();
    ej_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_ring(1'b1, 4'd0, 64'(k + 100));
      step();
    end
    set_ring(1'b0, '0, '0);
    check("sat.ej_cnt_wide",   64'(ej_cnt),   64'h5);
    check("sat.ej_cnt_narrow", 64'(s_ej_cnt), 64'h3);

    // Randomized traffic with a mid-run reset.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      ring_in_valid = ($urandom_range(0, 99) < 55);
      ring_in_dest  = ($urandom_range(0, 3) == 0) ? NODE_ID_W'(NODE_ID) : NODE_ID_W'($urandom_range(0, 15));
      ring_in_data  = {$urandom, $urandom};
      ej_ready      = ($urandom_range(0, 3) != 0);
      inj_valid     = NUM_CH'($urandom);
      inj_dest      = (NUM_CH*NODE_ID_W)'($urandom);
      for (int c = 0; c < NUM_CH; c++) inj_data[c*TAG_W +: TAG_W] = {$urandom, $urandom};
      step();
      check_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mby_tag_ring_uc_node.md
Name: mby_tag_ring_uc_node

Overview:
Parametrised unicast tag ring stop, the RTL successor of the single-channel unicast tag interface. It sits on the MBY tag ring with one ring slot in and one out per cycle. It ejects tags addressed to this node. When a slot is free, it injects local tags from NUM_CH buffered channels under round-robin arbitration. Saturating statistics counters are provided for the verification and debug path.

Parameters:
TAG_W, 64, tag payload width in bits
NODE_ID_W, 4, width of ring destination field
NODE_ID, 0, this stop's ring address (0..2**NODE_ID_W-1)
NUM_CH, 4, local injection channels (1..16)
FIFO_DEPTH, 8, entries per injection FIFO (power of 2, >=2)
CNT_W, 16, statistics counter width

Ports:
clk  in  1  ring clock
rst  in  1  asynchronous, active-low reset
ring_in_valid  in  1  upstream slot occupied
ring_in_dest  in  NODE_ID_W  upstream tag destination
ring_in_data  in  TAG_W  upstream tag payload
ring_out_valid  out  1  downstream slot occupied (registered)
ring_out_dest  out  NODE_ID_W  downstream destination (registered)
ring_out_data  out  TAG_W  downstream payload (registered)
inj_valid  in  NUM_CH  per-channel injection request
inj_ready  out  NUM_CH  per-channel FIFO not full
inj_dest  in  NUM_CH*NODE_ID_W  per-channel destination, channel c at [c*NODE_ID_W +: NODE_ID_W]
inj_data  in  NUM_CH*TAG_W  per-channel payload, same packing
ej_ready  in  1  local sink can accept a tag this cycle
ej_valid  out  1  ejected tag valid (registered, 1-cycle pulse per tag)
ej_data  out  TAG_W  ejected payload
inj_cnt  out  CNT_W  tags injected onto ring
ej_cnt  out  CNT_W  tags ejected
defl_cnt  out  CNT_W  tags for this node passed on because ej_ready=0

Behaviour:
- Reset: asynchronous assert, synchronous deassert is external. While rst=0, all outputs are 0 except inj_ready, which is 0 during reset and goes all-ones on the first clk after release. FIFOs are emptied, the RR pointer is set to 0 and counters to 0. Reset mid-operation drops all buffered and in-flight tags.
- Latency: ring_in to ring_out is exactly 1 cycle. ring_in to ej_valid is 1 cycle. inj push to earliest ring_out is 2 cycles; a tag pushed this cycle is not eligible for arbitration until the next cycle.
- Eject: if ring_in_valid and ring_in_dest==NODE_ID and ej_ready=1, the next cycle has ej_valid=1 and ej_data=ring_in_data, the slot is freed, and ej_cnt++. The sink commits to accept whenever it drives ej_ready=1; there is no back-pressure after that.
- Deflect: if ring_in_valid and ring_in_dest==NODE_ID and ej_ready=0, the tag is forwarded unchanged on ring_out and defl_cnt++.
- Pass-through: a valid tag for another node is forwarded unchanged. The slot is not free, so no injection occurs that cycle.
- Inject: a slot is free when ring_in_valid=0 or the tag is ejected that cycle. If the slot is free and any FIFO is non-empty, the RR arbiter grants one channel. Its head is popped onto ring_out next cycle and inj_cnt++. Eject and inject in the same cycle are legal and both counters increment.
- Arbiter: searches from rr_ptr upward, modulo NUM_CH. On a grant, rr_ptr becomes grant+1 mod NUM_CH. With no grant, rr_ptr holds.
- FIFO: push when inj_valid[c] && inj_ready[c]. inj_ready[c] = !full[c], taken from registered occupancy. When full, no push occurs even if a pop happens the same cycle. Pop and push on a non-full FIFO in the same cycle are both performed.
- Self-addressed injection (dest==NODE_ID) is legal. The tag travels the ring and is ejected on return.
- Idle: no valid slot and all FIFOs empty gives ring_out_valid=0, with ring_out_dest and ring_out_data held at 0.
- Counters saturate at 2**CNT_W-1 and do not wrap.

Test Plan:
- Reset: hold rst=0 with ring_in_valid=1 -> all outputs 0. Release -> next cycle inj_ready=4'b1111, counters 0.
- Pass-through: ring_in dest=3, data=0xA5 with NODE_ID=0 and ch0 holding a tag -> ring_out dest=3, data=0xA5 after 1 cycle. No injection, inj_cnt=0.
- Eject plus inject: ring_in dest=0, data=0x11, ej_ready=1, ch2 holding dest=5, data=0x22 -> next cycle ej_valid=1, ej_data=0x11, ring_out dest=5, data=0x22. ej_cnt=1, inj_cnt=1.
- Deflect: ring_in dest=0, ej_ready=0 -> ring_out carries the same tag, ej_valid=0, defl_cnt=1.
- Round-robin fairness: all 4 channels hold 3 tags each on an empty ring -> ring_out channel order is 0,1,2,3,0,1,2,3,0,1,2,3 on 12 consecutive cycles.
- Full FIFO and saturation: push 8 tags into ch1 on a fully occupied ring -> inj_ready[1]=0 after the 8th push and a 9th inj_valid is not accepted. With CNT_W=2, 5 ejects -> ej_cnt=3.
